// File: rtl/psum_out_collector.sv
// Collects skewed per-column psums from the systolic array's south edge into
// independent circular buffers and releases column-aligned rows under rd/out_vld.
module psum_out_collector #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic [psum_bw*col-1:0] out,
    output logic                   out_vld,
    output logic                   overflow
);

    localparam int aw = $clog2(depth);

    logic [col-1:0] empty_vec;
    logic [col-1:0] full_vec;
    logic [col-1:0] drop_vec;
    logic           rd_accept;
    logic           out_vld_reg;
    logic           overflow_reg;

    // Status depends only on registered pointers, never on this cycle's wr/rd.
    assign o_valid   = ~|empty_vec;
    assign o_full    = |full_vec;
    assign o_ready   = ~o_full;
    assign rd_accept = rd & o_valid;
    assign out_vld   = out_vld_reg;
    assign overflow  = overflow_reg;

    generate
        for (genvar gi = 0; gi < col; gi++) begin : g_col
            logic [psum_bw-1:0] mem [depth];
            logic [aw:0]        wptr_reg;
            logic [aw:0]        rptr_reg;
            logic [aw:0]        wptr_next;
            logic [aw:0]        rptr_next;
            logic [psum_bw-1:0] row_reg;
            logic               wr_en;

            // Extra MSB on the pointers separates full from empty when low bits match.
            assign empty_vec[gi] = (wptr_reg == rptr_reg);
            assign full_vec[gi]  = (wptr_reg[aw-1:0] == rptr_reg[aw-1:0]) &&
                                   (wptr_reg[aw] != rptr_reg[aw]);
            assign wr_en         = wr[gi] & ~full_vec[gi] & ~reset;
            assign drop_vec[gi]  = wr[gi] & full_vec[gi];
            assign wptr_next     = wptr_reg + (aw+1)'(1);
            assign rptr_next     = rptr_reg + (aw+1)'(1);

            always_ff @(posedge clk) begin
                if (wr_en) begin
                    mem[wptr_reg[aw-1:0]] <= in[psum_bw*gi +: psum_bw];
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    wptr_reg <= '0;
                    rptr_reg <= '0;
                    row_reg  <= '0;
                end else begin
                    if (wr_en) begin
                        wptr_reg <= wptr_next;
                    end
                    if (rd_accept) begin
                        row_reg  <= mem[rptr_reg[aw-1:0]];
                        rptr_reg <= rptr_next;
                    end
                end
            end

            assign out[psum_bw*gi +: psum_bw] = row_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            out_vld_reg  <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            out_vld_reg  <= rd_accept;
            overflow_reg <= overflow_reg | (|drop_vec);
        end
    end

endmodule

// File: tb/tb_psum_out_collector.sv
// Scoreboard bench for psum_out_collector: per-column reference queues feed an
// expected-row queue that is drained whenever the collector presents a row.
module tb_psum_out_collector;

    localparam int COL   = 8;
    localparam int BW    = 16;
    localparam int DEPTH = 64;
    localparam int W     = COL*BW;

    logic           clk = 1'b0;
    logic           reset;
    logic [W-1:0]   in_bus;
    logic [COL-1:0] wr;
    logic           rd;
    logic           o_valid, o_full, o_ready, out_vld, overflow;
    logic [W-1:0]   out;

    psum_out_collector #(.col(COL), .psum_bw(BW), .depth(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .in       (in_bus),
        .wr       (wr),
        .rd       (rd),
        .o_valid  (o_valid),
        .o_full   (o_full),
        .o_ready  (o_ready),
        .out      (out),
        .out_vld  (out_vld),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int           vec_count = 0;
    int           err_count = 0;
    int           rows_out  = 0;
    logic [BW-1:0] colq [COL][$];
    logic [W-1:0] exp_q [$];
    logic [W-1:0] out_mdl  = '0;
    bit           ovf_mdl  = 1'b0;
    bit           vld_mdl  = 1'b0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vec_count++;
        if (obs !== exp) begin
            err_count++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit mdl_valid();
        for (int c = 0; c < COL; c++)
            if (colq[c].size() == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit mdl_full();
        for (int c = 0; c < COL; c++)
            if (colq[c].size() == DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: decide from pre-edge model state, update at the edge, check #1 later.
    task automatic step();
        bit             acc;
        bit [COL-1:0]   full_pre;
        logic [W-1:0]   row;
        acc = !reset && rd && mdl_valid();
        for (int c = 0; c < COL; c++) full_pre[c] = (colq[c].size() == DEPTH);
        @(posedge clk);
        if (reset) begin
            for (int c = 0; c < COL; c++) colq[c].delete();
            exp_q.delete();
            out_mdl = '0;
            ovf_mdl = 1'b0;
            vld_mdl = 1'b0;
        end else begin
            vld_mdl = acc;
            if (acc) begin
                for (int c = 0; c < COL; c++) row[c*BW +: BW] = colq[c].pop_front();
                exp_q.push_back(row);
            end
            for (int c = 0; c < COL; c++) begin
                if (wr[c]) begin
                    if (full_pre[c]) ovf_mdl = 1'b1;
                    else colq[c].push_back(in_bus[c*BW +: BW]);
                end
            end
        end
        #1;
        check("out_vld", out_vld, vld_mdl);
        if (out_vld && exp_q.size() > 0) begin
            out_mdl = exp_q.pop_front();
            rows_out++;
            $display("row %0d: out=%h", rows_out, out);
        end
        check("out", out, out_mdl);
        check("o_valid", o_valid, mdl_valid());
        check("o_full", o_full, mdl_full());
        check("o_ready", o_ready, !mdl_full());
        check("overflow", overflow, ovf_mdl);
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // Column c written at cycle 10+c; rd raised at cycle 18 when the row completes.
    task automatic skewed_capture();
        for (int t = 0; t < 20; t++) begin
            wr = '0;
            rd = (t == 18);
            if (t >= 10 && t < 18) begin
                wr[t-10] = 1'b1;
                in_bus[(t-10)*BW +: BW] = 16'h0100 + 16'(t-10);
            end
            step();
            if (t == 16) check("valid_not_early", o_valid, 1'b0);
            if (t == 17) check("valid_at_18", o_valid, 1'b1);
            if (t == 18) check("skew_row", out, 128'h0107_0106_0105_0104_0103_0102_0101_0100);
        end
        wr = '0;
        rd = 1'b0;
    endtask

    int stream_base;

    initial begin
        reset  = 1'b1;
        wr     = '0;
        rd     = 1'b0;
        in_bus = '0;
        step();
        step();
        reset = 1'b0;

        // Skewed capture
        skewed_capture();

        // Fill column 0, overflow it, then drain 64 rows
        reset_pulse();
        for (int i = 0; i < DEPTH; i++) begin
            wr = 8'h01;
            in_bus[0 +: BW] = 16'(i);
            step();
        end
        wr = 8'h01;
        in_bus[0 +: BW] = 16'hBEEF;
        step();
        for (int i = 0; i < DEPTH; i++) begin
            wr = 8'hFE;
            for (int c = 1; c < COL; c++) in_bus[c*BW +: BW] = 16'h2000 + 16'(i*8 + c);
            step();
        end
        wr = '0;
        rd = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) step();

        // Ignored read: columns 0..6 only, rd held high
        wr = 8'h7F;
        for (int c = 0; c < COL; c++) in_bus[c*BW +: BW] = 16'h7000 + 16'(c);
        step();
        wr = '0;
        for (int i = 0; i < 4; i++) step();
        wr = 8'h80;
        in_bus[7*BW +: BW] = 16'h7007;
        step();
        wr = '0;
        for (int i = 0; i < 3; i++) step();
        rd = 1'b0;

        // Wrap-around streaming of 3*DEPTH skewed rows
        reset_pulse();
        stream_base = rows_out;
        for (int t = 0; t < 3*DEPTH + COL + 3; t++) begin
            wr = '0;
            for (int c = 0; c < COL; c++) begin
                if (t - c >= 0 && t - c < 3*DEPTH) begin
                    wr[c] = 1'b1;
                    in_bus[c*BW +: BW] = 16'((t - c)*8 + c);
                end
            end
            rd = mdl_valid();
            step();
        end
        wr = '0;
        rd = 1'b0;
        check("stream_rows", rows_out - stream_base, 3*DEPTH);

        // Full column 3 with simultaneous read and write
        reset_pulse();
        wr = 8'hFF;
        for (int c = 0; c < COL; c++) in_bus[c*BW +: BW] = 16'h5000 + 16'(c);
        step();
        for (int i = 1; i < DEPTH; i++) begin
            wr = 8'h08;
            in_bus[3*BW +: BW] = 16'h5300 + 16'(i);
            step();
        end
        wr = 8'h08;
        in_bus[3*BW +: BW] = 16'hDEAD;
        rd = 1'b1;
        step();
        check("same_edge_row", out, 128'h5007_5006_5005_5004_5003_5002_5001_5000);
        wr = '0;
        rd = 1'b0;
        step();
        check("col3_not_full", o_full, 1'b0);
        wr = 8'h08;
        in_bus[3*BW +: BW] = 16'h53FF;
        step();
        check("col3_full_again", o_full, 1'b1);
        wr = '0;

        // Reset with 5 rows buffered and rd high
        reset_pulse();
        for (int i = 0; i < 5; i++) begin
            wr = 8'hFF;
            for (int c = 0; c < COL; c++) in_bus[c*BW +: BW] = 16'h6000 + 16'(i*8 + c);
            step();
        end
        wr = '0;
        rd = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        rd = 1'b0;
        check("rst_out", out, '0);
        check("rst_o_ready", o_ready, 1'b1);
        skewed_capture();

        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
